// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the shared shift-add multiplier arbiter.
package mul_arb_pkg;

  // Default operand width; the product is twice as wide.
  localparam int WIDTH_DEF  = 8;
  localparam int RUN_CYCLES = WIDTH_DEF;
  localparam int PROD_W     = 2 * WIDTH_DEF;

  // Controller sequencing: accept, load engine, WIDTH add/shift steps, hold result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Product width for an arbitrary operand width.
  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/mul_engine.sv
// MSB-first shift-add multiplier datapath. The controller drives load/enable
// and the step index; the product register holds its value outside RUN.
module mul_engine
  import mul_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_load,
  input  logic                     i_enable,
  input  logic [WIDTH-1:0]         i_a,
  input  logic [WIDTH-1:0]         i_b,
  input  logic [CNT_W-1:0]         i_step,
  output logic [2*WIDTH-1:0]       o_product
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] r_product;
  logic [WIDTH-1:0]   r_mult;
  logic [2*WIDTH-1:0] w_addend;
  logic [2*WIDTH-1:0] w_sum;

  // Add A whenever the current multiplier MSB is set.
  assign w_addend = r_mult[WIDTH-1] ? {{WIDTH{1'b0}}, i_a} : '0;
  assign w_sum    = r_product + w_addend;

  // Load clears the accumulator; each step adds, then shifts except on the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_product <= '0;
      r_mult    <= '0;
    end else if (i_load) begin
      r_product <= '0;
      r_mult    <= i_b;
    end else if (i_enable) begin
      r_mult    <= r_mult << 1;
      r_product <= (i_step == LAST_STEP) ? w_sum : (w_sum << 1);
    end
  end

  assign o_product = r_product;

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin front end sharing one sequential multiplier among N_REQ
// requesters; one job in flight, result returned with the requester index.
module mul_share_arbiter
  import mul_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = WIDTH_DEF,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     rsp_valid,
  output logic [2*WIDTH-1:0]       rsp_c,
  output logic [ID_W-1:0]          rsp_id,
  input  logic                     rsp_ready,
  output logic                     busy
);

  localparam int               CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_REQ - 1);

  state_t             r_state;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [ID_W-1:0]    r_id;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_rsp_valid;
  logic [ID_W-1:0]    r_rsp_id;

  logic [ID_W:0]      w_pick;
  logic               w_found;
  logic [ID_W-1:0]    w_win_id;
  logic               w_accept;
  logic [WIDTH-1:0]   w_win_a;
  logic [WIDTH-1:0]   w_win_b;
  logic [2*WIDTH-1:0] w_product;

  // First valid requester at or after ptr (wrapping); MSB of result flags a hit.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] valid,
                                            input logic [ID_W-1:0]  ptr);
    logic [ID_W:0] res;
    int            idx;
    res = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!res[ID_W] && valid[idx]) res = {1'b1, ID_W'(idx)};
    end
    return res;
  endfunction

  assign w_pick   = rr_pick(req_valid, r_rr_ptr);
  assign w_found  = w_pick[ID_W];
  assign w_win_id = w_pick[ID_W-1:0];

  // Grant is offered only while idle; it is one-hot by construction.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
    assign req_ready[gi] = (r_state == IDLE) && w_found && (w_win_id == ID_W'(gi));
  end

  assign w_accept = |(req_valid & req_ready);
  assign w_win_a  = req_a[w_win_id*WIDTH +: WIDTH];
  assign w_win_b  = req_b[w_win_id*WIDTH +: WIDTH];

  // Controller: arbitration, operand capture, step sequencing and response hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a      <= w_win_a;
            r_b      <= w_win_b;
            r_id     <= w_win_id;
            r_rr_ptr <= (w_win_id == LAST_ID) ? '0 : w_win_id + 1'b1;
            r_state  <= LOAD;
          end
        end
        LOAD: begin
          r_cnt   <= '0;
          r_state <= RUN;
        end
        RUN: begin
          if (r_cnt == LAST_STEP) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  mul_engine #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_engine (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (r_state == LOAD),
    .i_enable  (r_state == RUN),
    .i_a       (r_a),
    .i_b       (r_b),
    .i_step    (r_cnt),
    .o_product (w_product)
  );

  // Product is only presented while a response is pending.
  assign rsp_valid = r_rsp_valid;
  assign rsp_c     = r_rsp_valid ? w_product : '0;
  assign rsp_id    = r_rsp_id;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mul_share_arbiter.sv
`timescale 1ns/1ps
module tb_mul_share_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*W-1:0]  req_a;
  logic [N*W-1:0]  req_b;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic [2*W-1:0]  rsp_c;
  logic [1:0]      rsp_id;
  logic            rsp_ready;
  logic            busy;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] c;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  mul_share_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_c     (rsp_c),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one request; on grant push the expected result. Returns at the
  // negedge (+1) of the cycle after the accept edge with req_valid dropped.
  task automatic issue(input int id, input logic [7:0] a, input logic [7:0] b,
                       output bit granted);
    exp_t e;
    granted = 1'b0;
    @(negedge clk);
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_valid[id]    = 1'b1;
    #1;
    for (int k = 0; k < 40; k++) begin
      if (req_ready[id]) begin
        granted = 1'b1;
        e.id = 2'(id);
        e.c  = 16'(a) * 16'(b);
        sb.push_back(e);
        break;
      end
      @(negedge clk); #1;
    end
    @(negedge clk);
    req_valid[id] = 1'b0;
    #1;
    $display("issue id=%0d a=%0d b=%0d granted=%0d", id, a, b, granted);
  endtask

  // Wait (bounded) for rsp_valid; lat counts negedges waited.
  task automatic wait_rsp(output bit ok, output int lat);
    ok  = 1'b0;
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      lat++;
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); else n_pass++;
    n_checks++; if (rsp_c !== 16'd0) $display("FAIL reset_rsp_c got=%0d exp=0", rsp_c); else n_pass++;
    n_checks++; if (rsp_id !== 2'd0) $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready got=%b exp=0000", req_ready); else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_single;
    bit ok; int lat; exp_t e;
    @(negedge clk);
    req_a[0 +: W] = 8'd3; req_b[0 +: W] = 8'd5; req_valid = 4'b0001;
    #1;
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL single_grant got=%b exp=0001", req_ready); else n_pass++;
    e.id = 2'd0; e.c = 16'd15; sb.push_back(e);
    @(negedge clk); req_valid = 4'b0000; #1;
    n_checks++; if (req_ready !== 4'b0000) $display("FAIL single_grant_once got=%b exp=0000", req_ready); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL single_busy got=%0b exp=1", busy); else n_pass++;
    wait_rsp(ok, lat);
    n_checks++; if (!ok || lat + 1 != 10) $display("FAIL single_latency got=%0d exp=10", lat + 1); else n_pass++;
    e = sb.pop_front();
    n_checks++; if (rsp_c !== e.c) $display("FAIL single_rsp_c got=%0d exp=%0d", rsp_c, e.c); else n_pass++;
    n_checks++; if (rsp_id !== e.id) $display("FAIL single_rsp_id got=%0d exp=%0d", rsp_id, e.id); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL single_rsp_drop got=%0b exp=0", rsp_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL single_idle got=%0b exp=0", busy); else n_pass++;
    $display("test_single rsp_c=%0d id=%0d lat=%0d", e.c, e.id, lat + 1);
  endtask

  task automatic test_max_zero;
    bit ok, g; int lat; exp_t e;
    logic [7:0] av[2]; logic [7:0] bv[2];
    av[0] = 8'd255; bv[0] = 8'd255; av[1] = 8'd0; bv[1] = 8'd200;
    for (int j = 0; j < 2; j++) begin
      issue(2, av[j], bv[j], g);
      n_checks++; if (!g) $display("FAIL maxzero_grant%0d got=0 exp=1", j); else n_pass++;
      wait_rsp(ok, lat);
      n_checks++; if (!ok || lat != 9) $display("FAIL maxzero_latency%0d got=%0d exp=9", j, lat); else n_pass++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++; if (rsp_c !== e.c) $display("FAIL maxzero_rsp_c%0d got=%0d exp=%0d", j, rsp_c, e.c); else n_pass++;
        n_checks++; if (rsp_id !== e.id) $display("FAIL maxzero_rsp_id%0d got=%0d exp=%0d", j, rsp_id, e.id); else n_pass++;
        $display("maxzero rsp_c=%0d exp=%0d id=%0d", rsp_c, e.c, rsp_id);
      end
    end
  endtask

  task automatic test_round_robin;
    exp_t e; int exp_id; int n_rsp; int cyc; int last_rsp;
    // Pulse reset so the pointer starts at requester 0.
    @(negedge clk); rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 8'(i + 2);
      req_b[i*W +: W] = 8'(i * 10 + 3);
    end
    req_valid = 4'b1111; rsp_ready = 1'b1;
    #1;
    exp_id = 0; n_rsp = 0; last_rsp = -1;
    for (cyc = 0; cyc < 80; cyc++) begin
      if (req_ready !== 4'b0000) begin
        n_checks++; if (req_ready !== 4'(1 << exp_id)) $display("FAIL rr_grant got=%b exp=%b", req_ready, 4'(1 << exp_id)); else n_pass++;
        e.id = 2'(exp_id);
        e.c  = 16'(exp_id + 2) * 16'(exp_id * 10 + 3);
        sb.push_back(e);
        exp_id = (exp_id + 1) % N;
      end
      if (rsp_valid) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          n_checks++; if (rsp_id !== e.id || rsp_c !== e.c) $display("FAIL rr_rsp got id=%0d c=%0d exp id=%0d c=%0d", rsp_id, rsp_c, e.id, e.c); else n_pass++;
        end
        if (last_rsp >= 0) begin
          n_checks++; if (cyc - last_rsp != 11) $display("FAIL rr_interval got=%0d exp=11", cyc - last_rsp); else n_pass++;
        end
        $display("rr rsp id=%0d c=%0d cycle=%0d", rsp_id, rsp_c, cyc);
        last_rsp = cyc;
        n_rsp++;
        if (n_rsp == 5) begin
          req_valid = 4'b0000;
          break;
        end
      end
      @(negedge clk); #1;
    end
    n_checks++; if (n_rsp != 5) $display("FAIL rr_count got=%0d exp=5", n_rsp); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL rr_idle got=%0b exp=0", busy); else n_pass++;
  endtask

  task automatic test_backpressure;
    bit ok, g; int lat; exp_t e;
    logic [15:0] c0; logic [1:0] id0;
    rsp_ready = 1'b0;
    issue(3, 8'd21, 8'd17, g);
    wait_rsp(ok, lat);
    n_checks++; if (!ok || lat != 9) $display("FAIL bp_latency got=%0d exp=9", lat); else n_pass++;
    c0 = rsp_c; id0 = rsp_id;
    req_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      n_checks++; if (rsp_valid !== 1'b1) $display("FAIL bp_valid_hold%0d got=%0b exp=1", k, rsp_valid); else n_pass++;
      n_checks++; if (rsp_c !== c0 || rsp_id !== id0) $display("FAIL bp_data_hold%0d got c=%0d id=%0d exp c=%0d id=%0d", k, rsp_c, rsp_id, c0, id0); else n_pass++;
      n_checks++; if (req_ready !== 4'b0000) $display("FAIL bp_no_grant%0d got=%b exp=0000", k, req_ready); else n_pass++;
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++; if (rsp_c !== e.c || rsp_id !== e.id) $display("FAIL bp_rsp got c=%0d id=%0d exp c=%0d id=%0d", rsp_c, rsp_id, e.c, e.id); else n_pass++;
    end
    req_valid = 4'b0000; rsp_ready = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL bp_release got=%0b exp=0", rsp_valid); else n_pass++;
    $display("backpressure c=%0d id=%0d", c0, id0);
  endtask

  task automatic test_reset_mid_job;
    bit ok, g; int lat; exp_t e;
    issue(1, 8'd10, 8'd10, g);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    if (sb.size() > 0) e = sb.pop_back();
    n_checks++; if (rsp_valid !== 1'b0 || rsp_c !== 16'd0 || rsp_id !== 2'd0) $display("FAIL midrst_rsp got v=%0b c=%0d id=%0d exp 0", rsp_valid, rsp_c, rsp_id); else n_pass++;
    n_checks++; if (busy !== 1'b0 || req_ready !== 4'b0000) $display("FAIL midrst_busy got busy=%0b ready=%b exp 0", busy, req_ready); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    issue(2, 8'd12, 8'd13, g);
    n_checks++; if (!g) $display("FAIL midrst_grant got=0 exp=1"); else n_pass++;
    wait_rsp(ok, lat);
    n_checks++; if (!ok || lat != 9) $display("FAIL midrst_latency got=%0d exp=9", lat); else n_pass++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++; if (rsp_c !== e.c || rsp_id !== e.id) $display("FAIL midrst_rsp2 got c=%0d id=%0d exp c=%0d id=%0d", rsp_c, rsp_id, e.c, e.id); else n_pass++;
    end
    $display("reset_mid_job rsp c=%0d id=%0d", rsp_c, rsp_id);
  endtask

  task automatic test_operand_change;
    bit ok, g; int lat; exp_t e;
    issue(1, 8'd7, 8'd9, g);
    req_a[1*W +: W] = 8'd1; req_b[1*W +: W] = 8'd1;
    wait_rsp(ok, lat);
    n_checks++; if (!ok) $display("FAIL opchg_timeout got=0 exp=1"); else n_pass++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++; if (rsp_c !== e.c || rsp_id !== e.id) $display("FAIL opchg_rsp got c=%0d id=%0d exp c=%0d id=%0d", rsp_c, rsp_id, e.c, e.id); else n_pass++;
    end
    $display("operand_change rsp c=%0d id=%0d", rsp_c, rsp_id);
  endtask

  initial begin
    test_reset();
    test_single();
    test_max_zero();
    test_round_robin();
    test_backpressure();
    test_reset_mid_job();
    test_operand_change();
    n_checks++; if (sb.size() != 0) $display("FAIL scoreboard_empty got=%0d exp=0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
